master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 172 +++++++++++++++++
 tb/tb_master_port.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// master_port: serial bus master. It requests the bus, shifts out a mode bit,
// a 12-bit address and (for writes) 8 data bits LSB first, or collects 8
// serial read bits. Grant loss or a read timeout aborts with an error pulse.
module master_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic        slave_sel,
  input  logic [11:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        error,
  output logic        port_busy,
  output logic        m_request,
  output logic        m_slave_select,
  input  logic        m_grant,
  output logic        m_dout,
  output logic        m_valid,
  input  logic        m_din,
  input  logic        m_rvalid
);

  typedef enum logic [2:0] {
    IDLE, REQ, MODE, ADDR, WDATA, RWAIT, RDATA, FIN
  } state_t;

  state_t      state;
  logic [3:0]  cnt;      // bit index in ADDR/WDATA/RDATA, idle-cycle count in RWAIT
  logic        rw_q;
  logic        sel_q;
  logic [11:0] addr_q;
  logic [7:0]  wdata_q;
  logic [6:0]  rbuf;     // read bits 0..6; bit 7 goes straight into rdata
  logic        granted_phase;
  logic        abort;

  // The arbiter must hold grant from MODE to the end of RDATA; losing it there,
  // or sitting through a 16th idle RWAIT cycle, terminates the transaction.
  assign granted_phase = (state inside {MODE, ADDR, WDATA, RWAIT, RDATA});
  assign abort = granted_phase &&
                 (!m_grant || (state == RWAIT && !m_rvalid && cnt == 4'd15));

  // Transaction FSM with registered outputs: each branch sets the outputs
  // that belong to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the latched request fields and read buffer are reset too, not just
      // the control state, so nothing from an interrupted transaction survives.
      state          <= IDLE;
      cnt            <= 4'd0;
      rw_q           <= 1'b0;
      sel_q          <= 1'b0;
      addr_q         <= 12'h000;
      wdata_q        <= 8'h00;
      rbuf           <= 7'h00;
      rdata          <= 8'h00;
      done           <= 1'b0;
      error          <= 1'b0;
      port_busy      <= 1'b0;
      m_request      <= 1'b0;
      m_slave_select <= 1'b0;
      m_valid        <= 1'b0;
      m_dout         <= 1'b0;
    end else begin
      // NOTE: pulses and the serial strobe default low every cycle; only the
      // branch entering the relevant state raises them, so none can stick.
      done    <= 1'b0;
      error   <= 1'b0;
      m_valid <= 1'b0;
      m_dout  <= 1'b0;
      if (abort) begin
        state          <= IDLE;
        cnt            <= 4'd0;
        error          <= 1'b1;
        port_busy      <= 1'b0;
        m_request      <= 1'b0;
        m_slave_select <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rw_q           <= rw;
              sel_q          <= slave_sel;
              addr_q         <= addr;
              wdata_q        <= wdata;
              cnt            <= 4'd0;
              state          <= REQ;
              port_busy      <= 1'b1;
              m_request      <= 1'b1;
              m_slave_select <= slave_sel;
            end
          end
          REQ: begin
            if (m_grant) begin
              state   <= MODE;
              m_valid <= 1'b1;
              m_dout  <= rw_q;
            end
          end
          MODE: begin
            state   <= ADDR;
            cnt     <= 4'd0;
            m_valid <= 1'b1;
            m_dout  <= addr_q[0];
          end
          ADDR: begin
            if (cnt == 4'd11) begin
              cnt <= 4'd0;
              if (rw_q) begin
                state   <= WDATA;
                m_valid <= 1'b1;
                m_dout  <= wdata_q[0];
              end else begin
                state <= RWAIT;
              end
            end else begin
              cnt     <= cnt + 4'd1;
              m_valid <= 1'b1;
              m_dout  <= addr_q[cnt + 4'd1];
            end
          end
          WDATA: begin
            if (cnt == 4'd7) begin
              state          <= FIN;
              cnt            <= 4'd0;
              done           <= 1'b1;
              m_request      <= 1'b0;
              m_slave_select <= 1'b0;
            end else begin
              cnt     <= cnt + 4'd1;
              m_valid <= 1'b1;
              m_dout  <= wdata_q[cnt[2:0] + 3'd1];
            end
          end
          RWAIT: begin
            if (m_rvalid) begin
              rbuf[0] <= m_din;
              cnt     <= 4'd1;
              state   <= RDATA;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          RDATA: begin
            // A cycle without m_rvalid simply stalls; there is no timeout here.
            if (m_rvalid) begin
              if (cnt == 4'd7) begin
                rdata          <= {m_din, rbuf};
                state          <= FIN;
                cnt            <= 4'd0;
                done           <= 1'b1;
                m_request      <= 1'b0;
                m_slave_select <= 1'b0;
              end else begin
                rbuf[cnt[2:0]] <= m_din;
                cnt            <= cnt + 4'd1;
              end
            end
          end
          FIN: begin
            state     <= IDLE;
            port_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port. Expected serial bits are queued when a
// transaction is launched and popped by a monitor whenever m_valid is high.
module tb_master_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rw;
  logic        slave_sel;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done;
  logic        error;
  logic        port_busy;
  logic        m_request;
  logic        m_slave_select;
  logic        m_grant;
  logic        m_dout;
  logic        m_valid;
  logic        m_din;
  logic        m_rvalid;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic exp_bits[$];

  master_port dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rw             (rw),
    .slave_sel      (slave_sel),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .done           (done),
    .error          (error),
    .port_busy      (port_busy),
    .m_request      (m_request),
    .m_slave_select (m_slave_select),
    .m_grant        (m_grant),
    .m_dout         (m_dout),
    .m_valid        (m_valid),
    .m_din          (m_din),
    .m_rvalid       (m_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_stream(input logic r, input logic [11:0] a, input logic [7:0] w,
                             input int na, input int nw);
    exp_bits.push_back(r);
    for (int i = 0; i < na; i++) exp_bits.push_back(a[i]);
    for (int i = 0; i < nw; i++) exp_bits.push_back(w[i]);
  endtask

  task automatic drive_start(input logic r, input logic s, input logic [11:0] a, input logic [7:0] w);
    rw        = r;
    slave_sel = s;
    addr      = a;
    wdata     = w;
    start     = 1'b1;
  endtask

  // Step until done or error (bounded) and check the latency and which pulse fired.
  task automatic wait_end(input string tag, input int exp_cycles, input logic exp_err);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(done || error) && n < 60);
    check({tag, " latency"}, n, exp_cycles);
    check({tag, " done"}, done, !exp_err);
    check({tag, " error"}, error, exp_err);
  endtask

  // Serial stream monitor and done/error exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid) begin
        check("m_valid with bits expected", m_valid, exp_bits.size() != 0);
        if (exp_bits.size() != 0) check("m_dout bit", m_dout, exp_bits.pop_front());
      end else begin
        check("m_dout idle", m_dout, 1'b0);
      end
      check("done and error together", done & error, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rbyte;
    reset = 1'b1; start = 1'b0; rw = 1'b0; slave_sel = 1'b0; addr = '0; wdata = '0;
    m_grant = 1'b0; m_din = 1'b0; m_rvalid = 1'b0;
    #3;
    check("reset outputs",
          {rdata, done, error, port_busy, m_request, m_slave_select, m_valid, m_dout}, 16'h0);

    // Write with grant after 3 REQ cycles; start on the first edge after reset.
    step();
    reset = 1'b0;
    drive_start(1'b1, 1'b1, 12'hA5C, 8'h3C);
    push_stream(1'b1, 12'hA5C, 8'h3C, 12, 8);
    step();
    start = 1'b0;
    check("wr REQ busy", port_busy, 1'b1);
    check("wr REQ request", m_request, 1'b1);
    check("wr REQ slave select", m_slave_select, 1'b1);
    check("wr REQ m_valid", m_valid, 1'b0);
    step();
    step();
    check("wr REQ held", m_request, 1'b1);
    m_grant = 1'b1;
    wait_end("wr", 22, 1'b0);
    check("wr FIN request", m_request, 1'b0);
    check("wr FIN slave select", m_slave_select, 1'b0);
    check("wr stream drained", exp_bits.size(), 0);
    step();
    check("wr done width", done, 1'b0);
    check("wr idle busy", port_busy, 1'b0);

    // Immediate grant: 23 cycles; a start pulse while busy is ignored.
    drive_start(1'b1, 1'b1, 12'h5A1, 8'hC3);
    push_stream(1'b1, 12'h5A1, 8'hC3, 12, 8);
    step();
    start = 1'b0;
    repeat (4) step();
    drive_start(1'b0, 1'b0, 12'hFFF, 8'h00);
    step();
    start = 1'b0;
    check("ignored start slave select", m_slave_select, 1'b1);
    wait_end("wr23", 17, 1'b0);
    check("wr23 stream drained", exp_bits.size(), 0);
    step();

    // Read of 8'h96 after a 2-cycle wait, with a one-cycle stall mid-byte.
    rbyte = 8'h96;
    drive_start(1'b0, 1'b0, 12'h001, 8'h00);
    push_stream(1'b0, 12'h001, 8'h00, 12, 0);
    step();
    start = 1'b0;
    repeat (13) step();
    step();
    step();
    check("rd RWAIT m_valid", m_valid, 1'b0);
    check("rd RWAIT busy", port_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        m_rvalid = 1'b0;
        step();
      end
      m_rvalid = 1'b1;
      m_din    = rbyte[i];
      if (i < 7) step();
    end
    check("rd rdata not early", rdata, 8'h00);
    wait_end("rd", 1, 1'b0);
    m_rvalid = 1'b0;
    check("rd rdata", rdata, 8'h96);
    check("rd stream drained", exp_bits.size(), 0);
    step();

    // Grant lost while address bit 5 is on the wire.
    drive_start(1'b1, 1'b1, 12'h7E3, 8'h55);
    push_stream(1'b1, 12'h7E3, 8'h55, 6, 0);
    step();
    start = 1'b0;
    repeat (7) step();
    m_grant = 1'b0;
    wait_end("grant loss", 1, 1'b1);
    check("grant loss request", m_request, 1'b0);
    check("grant loss m_valid", m_valid, 1'b0);
    check("grant loss busy", port_busy, 1'b0);
    check("grant loss rdata", rdata, 8'h96);
    check("grant loss stream drained", exp_bits.size(), 0);

    // Start during the error cycle, then read timeout with m_rvalid held low.
    m_grant = 1'b1;
    drive_start(1'b0, 1'b1, 12'h800, 8'h00);
    push_stream(1'b0, 12'h800, 8'h00, 12, 0);
    step();
    start = 1'b0;
    check("start in error cycle accepted", port_busy, 1'b1);
    check("error width", error, 1'b0);
    wait_end("timeout", 30, 1'b1);
    check("timeout rdata", rdata, 8'h96);
    check("timeout request", m_request, 1'b0);
    check("timeout stream drained", exp_bits.size(), 0);
    step();
    check("timeout error width", error, 1'b0);

    // Reset mid-WDATA, then a fresh write right after release.
    drive_start(1'b1, 1'b1, 12'h123, 8'hF0);
    push_stream(1'b1, 12'h123, 8'hF0, 12, 3);
    step();
    start = 1'b0;
    repeat (16) step();
    #2;
    reset = 1'b1;
    #1;
    check("async reset outputs",
          {rdata, done, error, port_busy, m_request, m_slave_select, m_valid, m_dout}, 16'h0);
    check("reset stream drained", exp_bits.size(), 0);
    step();
    reset = 1'b0;
    drive_start(1'b1, 1'b0, 12'h0F0, 8'hA5);
    push_stream(1'b1, 12'h0F0, 8'hA5, 12, 8);
    step();
    start = 1'b0;
    check("post-reset slave select", m_slave_select, 1'b0);
    wait_end("post-reset wr", 22, 1'b0);
    check("post-reset stream drained", exp_bits.size(), 0);
    step();
    check("post-reset idle", port_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
